// File: rtl/icap_portal_ctrl_if.sv
// ICAP-style configuration port bundle.
// Carries the chip select, the write/read select, the write data beat, the busy flag
// and the readback data beat.
// The CW parameter must match the CW of the controller the bundle is connected to.
`timescale 1ns/1ps
interface icap_portal_ctrl_if #(
  parameter int unsigned CW = 32
);
  logic          ccs_n;
  logic          cwe_n;
  logic [CW-1:0] cdata;
  logic          cbusy;
  logic [CW-1:0] cdata_rb;

  modport master (output ccs_n, cwe_n, cdata, input cbusy, cdata_rb);
  modport slave  (input ccs_n, cwe_n, cdata, output cbusy, cdata_rb);
endinterface

// File: rtl/icap_portal_ctrl.sv
// icap_portal_ctrl: multi-region reconfiguration portal controller.
// Assembles 32-bit words from CW-bit write beats, with the first beat in the MSBs.
// Decodes SYNC / BEGIN / LEN / data / END / DESYNC commands.
// Accumulates an XOR signature over the payload and checks it against module_sgnts.
// Ports:
//   clk, rstn         clock and asynchronous active-low reset
//   icap (slave)      ccs_n, cwe_n, cdata in; cbusy, cdata_rb out
//   module_sgnts      expected signature of region r, module m at [(r*NUM_RM+m)*32 +: 32]
//   active_module_id  8-bit active module per region
//   reconf_phase      per-region "reconfiguration in progress"
//   sei_en, dei_en    per-region error-injection enables
// Macro RSV_ERR_INJ_EN enables the error-injection logic.
// Without it, sei_en and dei_en are tied to 0.
`timescale 1ns/1ps
module icap_portal_ctrl #(
  parameter int unsigned NUM_RR = 2,
  parameter int unsigned NUM_RM = 4,
  parameter int unsigned CW     = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  icap_portal_ctrl_if.slave            icap,
  input  logic [NUM_RR*NUM_RM*32-1:0]  module_sgnts,
  output logic [NUM_RR*8-1:0]          active_module_id,
  output logic [NUM_RR-1:0]            reconf_phase,
  output logic [NUM_RR-1:0]            sei_en,
  output logic [NUM_RR-1:0]            dei_en
);
  localparam int unsigned BEATS = 32 / CW;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] SYNC_WORD = 32'hAA99_5566;
  localparam logic [3:0]  OP_BEGIN  = 4'h1;
  localparam logic [3:0]  OP_END    = 4'h2;
  localparam logic [3:0]  OP_DESYNC = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t                state, state_d;
  logic [31:0]           shreg, sh_d;
  logic [BCW-1:0]        beat_cnt, beat_d, rd_cnt, rd_d;
  logic [31:0]           acc, acc_d, cnt, cnt_d;
  logic [7:0]            pend_rr, pend_rr_d, pend_rm, pend_rm_d;
  logic                  pend_vld, pend_vld_d;
  logic [7:0]            last_rr, last_rr_d, last_rm, last_rm_d, done_cnt, done_d;
  logic                  sig_err, sig_err_d, bad_cmd, bad_cmd_d;
  logic [NUM_RR*8-1:0]   amid_d;
  logic [NUM_RR-1:0]     phase_d;
  logic                  cbusy_q, cbusy_d;
  logic [CW-1:0]         rb_q, rb_d;

  logic                  wr_beat_c, rd_beat_c, word_done_c;
  logic [31:0]           word_c, exp_sig_c, status_c;
  logic [3:0]            op_c;
  logic [7:0]            rr_c, rm_c;
  logic                  rr_ok_c, rm_ok_c, phase_rr_c;
  logic [CW-1:0]         rb_c;
  logic                  chk_pass_c, chk_fail_c;

  assign icap.cbusy    = cbusy_q;
  assign icap.cdata_rb = rb_q;

  // Beat qualification; write beats are dropped while the signature check runs.
  assign wr_beat_c   = !icap.ccs_n && !icap.cwe_n && !cbusy_q;
  assign rd_beat_c   = !icap.ccs_n && icap.cwe_n;
  assign word_done_c = wr_beat_c && (beat_cnt == BCW'(BEATS - 1));
  // Older beats shift up so the first beat ends in the MSBs.
  // For CW=32 the truncation leaves only the current beat.
  assign word_c      = 32'({shreg, icap.cdata});

  assign op_c       = word_c[31:28];
  assign rr_c       = word_c[23:16];
  assign rm_c       = word_c[7:0];
  assign rr_ok_c    = 32'(rr_c) < NUM_RR;
  assign rm_ok_c    = 32'(rm_c) < NUM_RM;
  assign phase_rr_c = 1'(reconf_phase >> rr_c);
  assign exp_sig_c  = 32'(module_sgnts >> (32 * (32'(pend_rr) * NUM_RM + 32'(pend_rm))));

  assign status_c = {sig_err, bad_cmd, state, 3'b000, last_rr, last_rm, done_cnt};
  assign rb_c     = CW'(status_c >> (CW * (BEATS - 1 - 32'(rd_cnt))));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_IDLE;
      shreg            <= '0;
      beat_cnt         <= '0;
      rd_cnt           <= '0;
      acc              <= '0;
      cnt              <= '0;
      pend_rr          <= '0;
      pend_rm          <= '0;
      pend_vld         <= 1'b0;
      last_rr          <= '0;
      last_rm          <= '0;
      done_cnt         <= '0;
      sig_err          <= 1'b0;
      bad_cmd          <= 1'b0;
      active_module_id <= '0;
      reconf_phase     <= '0;
      cbusy_q          <= 1'b0;
      rb_q             <= '0;
    end else begin
      state            <= state_d;
      shreg            <= sh_d;
      beat_cnt         <= beat_d;
      rd_cnt           <= rd_d;
      acc              <= acc_d;
      cnt              <= cnt_d;
      pend_rr          <= pend_rr_d;
      pend_rm          <= pend_rm_d;
      pend_vld         <= pend_vld_d;
      last_rr          <= last_rr_d;
      last_rm          <= last_rm_d;
      done_cnt         <= done_d;
      sig_err          <= sig_err_d;
      bad_cmd          <= bad_cmd_d;
      active_module_id <= amid_d;
      reconf_phase     <= phase_d;
      cbusy_q          <= cbusy_d;
      rb_q             <= rb_d;
    end
  end

  // Next-state, command decode and output update.
  always_comb begin
    state_d    = state;
    sh_d       = shreg;
    beat_d     = beat_cnt;
    rd_d       = rd_cnt;
    acc_d      = acc;
    cnt_d      = cnt;
    pend_rr_d  = pend_rr;
    pend_rm_d  = pend_rm;
    pend_vld_d = pend_vld;
    last_rr_d  = last_rr;
    last_rm_d  = last_rm;
    done_d     = done_cnt;
    sig_err_d  = sig_err;
    bad_cmd_d  = bad_cmd;
    amid_d     = active_module_id;
    phase_d    = reconf_phase;
    rb_d       = rb_q;
    chk_pass_c = 1'b0;
    chk_fail_c = 1'b0;

    // Deselect discards any partial word and restarts the readback sequence.
    if (icap.ccs_n) begin
      beat_d = '0;
      rd_d   = '0;
    end else if (wr_beat_c) begin
      sh_d   = word_c;
      beat_d = (beat_cnt == BCW'(BEATS - 1)) ? '0 : beat_cnt + BCW'(1);
    end else if (rd_beat_c) begin
      rb_d = rb_c;
      rd_d = (rd_cnt == BCW'(BEATS - 1)) ? '0 : rd_cnt + BCW'(1);
    end

    case (state)
      S_IDLE: begin
        if (word_done_c && word_c == SYNC_WORD) state_d = S_HDR;
      end
      S_HDR: begin
        if (word_done_c) begin
          case (op_c)
            OP_BEGIN: begin
              // Only one region may be in flight; a BEGIN for that same region restarts it.
              if (!rr_ok_c || !rm_ok_c || (pend_vld && rr_c != pend_rr)) begin
                bad_cmd_d = 1'b1;
              end else begin
                for (int unsigned r = 0; r < NUM_RR; r++)
                  if (r == 32'(rr_c)) phase_d[r] = 1'b1;
                pend_rr_d  = rr_c;
                pend_rm_d  = rm_c;
                pend_vld_d = 1'b1;
                acc_d      = '0;
                last_rr_d  = rr_c;
                last_rm_d  = rm_c;
                state_d    = S_LEN;
              end
            end
            OP_END: begin
              if (!rr_ok_c || !rm_ok_c || !phase_rr_c) begin
                bad_cmd_d = 1'b1;
              end else begin
                last_rr_d = rr_c;
                last_rm_d = rm_c;
                state_d   = S_CHECK;
              end
            end
            OP_DESYNC: state_d = S_IDLE;
            default:   bad_cmd_d = 1'b1;
          endcase
        end
      end
      S_LEN: begin
        if (word_done_c) begin
          cnt_d   = word_c;
          state_d = (word_c == 32'd0) ? S_HDR : S_DATA;
        end
      end
      S_DATA: begin
        if (word_done_c) begin
          acc_d = acc ^ word_c;
          cnt_d = cnt - 32'd1;
          if (cnt == 32'd1) state_d = S_HDR;
        end
      end
      S_CHECK: begin
        state_d = S_HDR;
        if (acc == exp_sig_c) begin
          chk_pass_c = 1'b1;
          for (int unsigned r = 0; r < NUM_RR; r++) begin
            if (r == 32'(pend_rr)) begin
              amid_d[r*8 +: 8] = pend_rm;
              phase_d[r]       = 1'b0;
            end
          end
          done_d     = done_cnt + 8'd1;
          pend_vld_d = 1'b0;
        end else begin
          chk_fail_c = 1'b1;
          sig_err_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cbusy_d = (state_d == S_CHECK);
  end

`ifdef RSV_ERR_INJ_EN
  logic [NUM_RR-1:0] dei_hold, dei_hold_d;

  // A failed check holds the dynamic-side injection until that region passes a check.
  always_comb begin
    dei_hold_d = dei_hold;
    for (int unsigned r = 0; r < NUM_RR; r++) begin
      if (r == 32'(pend_rr)) begin
        if (chk_pass_c)      dei_hold_d[r] = 1'b0;
        else if (chk_fail_c) dei_hold_d[r] = 1'b1;
      end
    end
  end

  // Injection enables register together with reconf_phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dei_hold <= '0;
      sei_en   <= '0;
      dei_en   <= '0;
    end else begin
      dei_hold <= dei_hold_d;
      sei_en   <= phase_d;
      dei_en   <= phase_d | dei_hold_d;
    end
  end
`else
  assign sei_en = '0;
  assign dei_en = '0;
`endif

endmodule
